// File: rtl/rc4_crack_scheduler.sv
// rc4_crack_scheduler: N-core supervisor for the RC4 brute-force key search.
// Splits 0..2**KEY_SPACE_BITS-1 into NUM_CORES equal slices, launches every
// core with a single pulse, halts all cores on the first hit and latches the
// winning key/core, and counts the cycles the search took (saturating).
// Optional feature macro: CRACK_TIMEOUT_EN. When defined, a search with no hit
// aborts after TIMEOUT_CYCLES-1 counted cycles and reports timed_out.
module rc4_crack_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int KEY_W          = 24,
  parameter int KEY_SPACE_BITS = 22,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 2**30,
  localparam int IDX_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_min_key,
  output logic [NUM_CORES*KEY_W-1:0] core_max_key,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES-1:0]       core_not_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       halt,
  output logic                       busy,
  output logic                       found,
  output logic                       not_found,
  output logic                       timed_out,
  output logic [KEY_W-1:0]           key,
  output logic [IDX_W-1:0]           winner_idx,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_SEARCH    = 3'd2;
  localparam logic [2:0] S_FOUND     = 3'd3;
  localparam logic [2:0] S_EXHAUSTED = 3'd4;

`ifdef CRACK_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Slice size computed one bit wider so a full KEY_W-bit space still fits.
  localparam logic [KEY_W:0] SPACE = (KEY_W+1)'(1) << KEY_SPACE_BITS;
  localparam logic [KEY_W:0] SLICE = SPACE / (KEY_W+1)'(NUM_CORES);

  logic [2:0]           state_reg;
  logic [NUM_CORES-1:0] done_mask_reg;
  logic                 found_reg;
  logic                 not_found_reg;
  logic                 timed_out_reg;
  logic [KEY_W-1:0]     key_reg;
  logic [IDX_W-1:0]     winner_idx_reg;
  logic [CNT_W-1:0]     cycle_count_reg;

  logic [NUM_CORES-1:0] done_mask_next;
  logic [CNT_W-1:0]     cycle_count_next;
  logic [IDX_W-1:0]     hit_idx;
  logic [KEY_W-1:0]     hit_key;
  logic                 timeout_hit;
  logic                 launching;
  logic                 searching;

  // Constant slice bounds per core.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slice
      localparam logic [KEY_W:0] LO = SLICE * (KEY_W+1)'(gi);
      localparam logic [KEY_W:0] HI = LO + SLICE - (KEY_W+1)'(1);
      assign core_min_key[gi*KEY_W +: KEY_W] = LO[KEY_W-1:0];
      assign core_max_key[gi*KEY_W +: KEY_W] = HI[KEY_W-1:0];
    end
  endgenerate

  // Priority pick of the lowest-index core reporting a hit this cycle.
  always_comb begin
    hit_idx = '0;
    hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        hit_idx = IDX_W'(i);
        hit_key = core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Completion mask including this cycle's reports, saturating counter, timeout.
  always_comb begin
    done_mask_next   = done_mask_reg | core_found | core_not_found;
    cycle_count_next = (&cycle_count_reg) ? cycle_count_reg
                                          : cycle_count_reg + CNT_W'(1);
    timeout_hit      = TIMEOUT_ON && (cycle_count_reg == TIMEOUT_LAST);
  end

  // Supervisor FSM and result registers; a hit beats exhaustion beats timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      done_mask_reg   <= '0;
      found_reg       <= 1'b0;
      not_found_reg   <= 1'b0;
      timed_out_reg   <= 1'b0;
      key_reg         <= '0;
      winner_idx_reg  <= '0;
      cycle_count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state_reg       <= S_LAUNCH;
            done_mask_reg   <= '0;
            found_reg       <= 1'b0;
            not_found_reg   <= 1'b0;
            timed_out_reg   <= 1'b0;
            key_reg         <= '0;
            winner_idx_reg  <= '0;
            cycle_count_reg <= '0;
          end
        end
        S_LAUNCH: begin
          state_reg <= S_SEARCH;
        end
        S_SEARCH: begin
          done_mask_reg   <= done_mask_next;
          cycle_count_reg <= cycle_count_next;
          if (|core_found) begin
            state_reg      <= S_FOUND;
            found_reg      <= 1'b1;
            key_reg        <= hit_key;
            winner_idx_reg <= hit_idx;
          end else if (&done_mask_next) begin
            state_reg     <= S_EXHAUSTED;
            not_found_reg <= 1'b1;
          end else if (timeout_hit) begin
            // Freeze the count at the limit that triggered the abort.
            state_reg       <= S_EXHAUSTED;
            timed_out_reg   <= 1'b1;
            cycle_count_reg <= cycle_count_reg;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Status decoded straight from the state register; launch pulse masked by reset.
  always_comb begin
    launching   = (state_reg == S_LAUNCH);
    searching   = (state_reg == S_SEARCH);
    core_start  = {NUM_CORES{launching && !reset}};
    halt        = !(launching || searching);
    busy        = launching || searching;
    found       = found_reg;
    not_found   = not_found_reg;
    timed_out   = timed_out_reg;
    key         = key_reg;
    winner_idx  = winner_idx_reg;
    cycle_count = cycle_count_reg;
  end

endmodule
